// File: rtl/interp_block_ctrl_pkg.sv
// Shared definitions for the interpolation block-loop controller.
//   state_t          : controller state encodings (binary)
//   BLK_IDX_W        : width of the block index / count register
//   TMR_W            : width of the inline load timer
//   LOAD_CYCLES_MIN/MAX : legal range of the LOAD_CYCLES parameter
package interp_block_ctrl_pkg;

  localparam int unsigned BLK_IDX_W       = 4;
  localparam int unsigned TMR_W           = 4;
  localparam int unsigned LOAD_CYCLES_MIN = 1;
  localparam int unsigned LOAD_CYCLES_MAX = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FIRE = 3'd2,
    ST_WAIT = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/interp_block_ctrl_cnt.sv
// Block-counter register written by the block-loop controller.
//   CLK         : clock, rising edge
//   RST_ASYNC_N : asynchronous active-low reset, clears the count
//   WRITE_EN    : load DATA_IN on the next rising edge
//   DATA_IN     : value to load
//   DATA_OUT    : current count
module interp_block_ctrl_cnt
  import interp_block_ctrl_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_ASYNC_N,
  input  logic                 WRITE_EN,
  input  logic [BLK_IDX_W-1:0] DATA_IN,
  output logic [BLK_IDX_W-1:0] DATA_OUT
);

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      DATA_OUT <= '0;
    end else if (WRITE_EN) begin
      DATA_OUT <= DATA_IN;
    end
  end

endmodule

// File: rtl/interp_block_ctrl.sv
// Sequencing controller for the interpolation block loop.
// For each block index 0..LAST_BLK: hold BUF_LOAD_EN for LOAD_CYCLES cycles,
// pulse DP_START, then wait for DP_DONE. The block index lives in an
// external count register written through CNT_WE/CNT_D and read via CNT_Q.
//   CLK, RST_ASYNC_N : clock (rising edge), async active-low reset
//   START, ABORT     : host run / cancel controls
//   LAST_BLK         : final block index, latched when START is accepted
//   DP_DONE          : datapath finished current block (honoured in WAIT only)
//   CNT_Q            : count register readback
//   CNT_WE, CNT_D    : count register write port (combinational)
//   BUF_LOAD_EN      : reference-buffer load enable
//   DP_START         : one-cycle datapath start pulse
//   BUSY, DONE       : run in progress / normal completion pulse
module interp_block_ctrl
  import interp_block_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST_ASYNC_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [BLK_IDX_W-1:0] LAST_BLK,
  input  logic                 DP_DONE,
  input  logic [BLK_IDX_W-1:0] CNT_Q,
  output logic                 CNT_WE,
  output logic [BLK_IDX_W-1:0] CNT_D,
  output logic                 BUF_LOAD_EN,
  output logic                 DP_START,
  output logic                 BUSY,
  output logic                 DONE
);

  if (LOAD_CYCLES < LOAD_CYCLES_MIN || LOAD_CYCLES > LOAD_CYCLES_MAX) begin : g_bad_load_cycles
    $error("interp_block_ctrl: LOAD_CYCLES out of legal range");
  end

  localparam logic [TMR_W-1:0] LOAD_LAST = TMR_W'(LOAD_CYCLES - 1);

  state_t               state_q;
  state_t               state_n;
  logic [BLK_IDX_W-1:0] last_q;
  logic [TMR_W-1:0]     tmr_q;

  logic start_acc;
  logic blk_next;
  logic abort_clr;

  // Transition qualifiers shared by the register, next-state and write-port logic.
  assign start_acc = (state_q == ST_IDLE) && START && !ABORT;
  assign blk_next  = (state_q == ST_WAIT) && !ABORT && DP_DONE && (CNT_Q != last_q);
  assign abort_clr = (state_q != ST_IDLE) && ABORT;

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q <= ST_IDLE;
      last_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_n;
      if (start_acc) begin
        last_q <= LAST_BLK;
      end
      if (start_acc || blk_next) begin
        tmr_q <= '0;
      end else if (state_q == ST_LOAD) begin
        tmr_q <= tmr_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    if (abort_clr) begin
      state_n = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_acc)           state_n = ST_LOAD;
        ST_LOAD: if (tmr_q == LOAD_LAST)  state_n = ST_FIRE;
        ST_FIRE:                          state_n = ST_WAIT;
        ST_WAIT: if (DP_DONE)             state_n = (CNT_Q == last_q) ? ST_FIN : ST_LOAD;
        ST_FIN:                           state_n = ST_IDLE;
        default:                          state_n = ST_IDLE;
      endcase
    end
  end

  // The write port is combinational from inputs, so it is gated by reset to
  // keep every output low while RST_ASYNC_N is asserted.
  always_comb begin
    BUF_LOAD_EN = (state_q == ST_LOAD);
    DP_START    = (state_q == ST_FIRE);
    BUSY        = (state_q != ST_IDLE);
    DONE        = (state_q == ST_FIN);
    CNT_WE      = RST_ASYNC_N && (start_acc || blk_next || abort_clr);
    CNT_D       = '0;
    if (RST_ASYNC_N && blk_next) begin
      CNT_D = CNT_Q + 1'b1;
    end
  end

endmodule

// File: tb/tb_interp_block_ctrl.sv
module tb_interp_block_ctrl;
  import interp_block_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_ASYNC_N = 1'b0;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [3:0] LAST_BLK = '0;
  logic       DP_DONE = 1'b0;
  logic [3:0] CNT_Q;
  logic       CNT_WE;
  logic [3:0] CNT_D;
  logic       BUF_LOAD_EN;
  logic       DP_START;
  logic       BUSY;
  logic       DONE;

  int checks = 0;
  int passed = 0;

  interp_block_ctrl #(.LOAD_CYCLES(4)) dut (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .START(START), .ABORT(ABORT),
    .LAST_BLK(LAST_BLK), .DP_DONE(DP_DONE), .CNT_Q(CNT_Q), .CNT_WE(CNT_WE),
    .CNT_D(CNT_D), .BUF_LOAD_EN(BUF_LOAD_EN), .DP_START(DP_START),
    .BUSY(BUSY), .DONE(DONE)
  );

  interp_block_ctrl_cnt u_cnt (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .WRITE_EN(CNT_WE),
    .DATA_IN(CNT_D), .DATA_OUT(CNT_Q)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Starts a run and drives DP_DONE dly cycles after each DP_START.
  // abort_idx: raise ABORT together with DP_DONE at that index (-1 = never).
  // stop_idx : return in the first WAIT cycle of that index (-1 = never).
  task automatic run_blocks(input logic [3:0] last, input int dly,
                            input int abort_idx, input int stop_idx,
                            output int n_load, output int n_start,
                            output int n_done, output int n_busy,
                            output bit seq_ok, output bit abort_ok,
                            output bit finished);
    int cd;
    n_load = 0; n_start = 0; n_done = 0; n_busy = 0;
    seq_ok = 1'b1; abort_ok = 1'b0; finished = 1'b0; cd = -1;
    START = 1'b1; LAST_BLK = last;
    tick();
    START = 1'b0; LAST_BLK = ~last;
    for (int i = 0; i < 2000; i++) begin
      ABORT = 1'b0;
      DP_DONE = 1'b0;
      if (!BUSY) begin
        finished = 1'b1;
        break;
      end
      n_busy++;
      if (BUF_LOAD_EN) n_load++;
      if (DONE) n_done++;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          DP_DONE = 1'b1;
          if (abort_idx >= 0 && int'(CNT_Q) == abort_idx) ABORT = 1'b1;
        end
      end
      if (DP_START) begin
        n_start++;
        if (int'(CNT_Q) != n_start - 1) seq_ok = 1'b0;
        cd = dly;
        if (stop_idx >= 0 && int'(CNT_Q) == stop_idx) begin
          tick();
          finished = 1'b1;
          return;
        end
      end
      #1;
      if (ABORT) abort_ok = (CNT_WE === 1'b1) && (CNT_D === 4'd0);
      tick();
    end
    ABORT = 1'b0;
    DP_DONE = 1'b0;
  endtask

  initial begin
    int nl, ns, nd, nb, first_done, second_done, idle_cnt, cyc, dps;
    bit sok, aok, fin;

    // Reset state
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_outs", {CNT_WE, CNT_D, BUF_LOAD_EN, DP_START, DONE}, 0);
    #13 RST_ASYNC_N = 1'b1;
    tick();
    chk("post_rst_busy", BUSY, 0);

    // Single block, DP_DONE 3 cycles after DP_START
    START = 1'b1; LAST_BLK = 4'd0;
    #1;
    chk("start_we", {CNT_WE, CNT_D}, {1'b1, 4'd0});
    START = 1'b0;
    run_blocks(4'd0, 3, -1, -1, nl, ns, nd, nb, sok, aok, fin);
    chk("b0_finished", fin, 1);
    chk("b0_loads", nl, 4);
    chk("b0_starts", ns, 1);
    chk("b0_done", nd, 1);
    chk("b0_busy_cycles", nb, 9);
    chk("b0_cnt_end", CNT_Q, 0);

    // Sixteen blocks, DP_DONE on the first WAIT cycle
    run_blocks(4'd15, 1, -1, -1, nl, ns, nd, nb, sok, aok, fin);
    chk("b15_finished", fin, 1);
    chk("b15_loads", nl, 64);
    chk("b15_starts", ns, 16);
    chk("b15_done", nd, 1);
    chk("b15_seq", sok, 1);
    chk("b15_busy_cycles", nb, 97);
    chk("b15_cnt_end", CNT_Q, 15);

    // ABORT coincident with DP_DONE at index 7
    run_blocks(4'd15, 1, 7, -1, nl, ns, nd, nb, sok, aok, fin);
    chk("ab_finished", fin, 1);
    chk("ab_starts", ns, 8);
    chk("ab_done", nd, 0);
    chk("ab_we_clear", aok, 1);
    chk("ab_busy_cycles", nb, 48);
    chk("ab_cnt", CNT_Q, 0);
    dps = 0;
    for (int i = 0; i < 8; i++) begin
      if (DP_START || BUSY) dps++;
      tick();
    end
    chk("ab_quiet", dps, 0);

    // Asynchronous reset in WAIT with CNT_Q=5
    run_blocks(4'd15, 50, -1, 5, nl, ns, nd, nb, sok, aok, fin);
    chk("mid_wait_busy", BUSY, 1);
    chk("mid_wait_cnt", CNT_Q, 5);
    #2 RST_ASYNC_N = 1'b0;
    #1;
    chk("async_rst_outs", {BUSY, CNT_WE, CNT_D, BUF_LOAD_EN, DP_START, DONE}, 0);
    chk("async_rst_cnt", CNT_Q, 0);
    #2 RST_ASYNC_N = 1'b1;
    tick();
    chk("rerst_busy", BUSY, 0);
    run_blocks(4'd0, 1, -1, -1, nl, ns, nd, nb, sok, aok, fin);
    chk("restart_seq", sok, 1);
    chk("restart_done", nd, 1);

    // Stray DP_DONE held through LOAD/FIRE, stray START mid-run
    START = 1'b1; LAST_BLK = 4'd1; DP_DONE = 1'b1;
    tick();
    START = 1'b0; LAST_BLK = 4'd9;
    for (int i = 0; i < 4; i++) tick();
    chk("stray_fire", DP_START, 1);
    tick();
    chk("stray_wait_busy", {BUSY, BUF_LOAD_EN, DP_START}, 3'b100);
    chk("stray_wait_we", {CNT_WE, CNT_D}, {1'b1, 4'd1});
    START = 1'b1;
    tick();
    chk("stray_load1", {BUF_LOAD_EN, CNT_Q}, {1'b1, 4'd1});
    for (int i = 0; i < 5; i++) tick();
    chk("stray_last_we", CNT_WE, 0);
    START = 1'b0;
    tick();
    chk("stray_done", DONE, 1);
    DP_DONE = 1'b0;
    tick();
    chk("stray_idle", BUSY, 0);

    // START held: back-to-back runs with LAST_BLK=2
    START = 1'b1; LAST_BLK = 4'd2; DP_DONE = 1'b1;
    tick();
    first_done = -1; second_done = -1; idle_cnt = 0; dps = 0; cyc = 1;
    for (int i = 0; i < 200; i++) begin
      if (!BUSY) idle_cnt++;
      if (DP_START) dps++;
      if (DONE) begin
        if (first_done < 0) first_done = cyc;
        else begin
          second_done = cyc;
          break;
        end
      end
      tick();
      cyc++;
    end
    START = 1'b0; DP_DONE = 1'b0;
    chk("b2b_first_done", first_done, 19);
    chk("b2b_second_done", second_done, 39);
    chk("b2b_idle_cycles", idle_cnt, 1);
    chk("b2b_starts", dps, 6);
    tick();
    chk("b2b_end_idle", BUSY, 0);
    chk("b2b_cnt", CNT_Q, 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
